// File: rtl/idma_rd_pkg.sv
// rtl/idma_rd_pkg.sv - shared constants, FSM state type and burst sizing helper for the iDMA read path
package idma_rd_pkg;

  localparam int unsigned BEAT_BYTES = 16;
  localparam int unsigned BEAT_SHIFT = 4;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_WAIT_R
  } rd_state_e;

  // Smallest of remaining beats, per-burst cap and beats left in the current page.
  function automatic logic [8:0] burst_beats(input logic [31:0] rem,
                                             input logic [8:0]  cap,
                                             input logic [8:0]  page);
    logic [8:0] b;
    b = cap;
    if (page < b) b = page;
    if (rem < {23'd0, b}) b = rem[8:0];
    return b;
  endfunction

endpackage

// File: rtl/axi_rd_burst_gen_if.sv
// rtl/axi_rd_burst_gen_if.sv - AXI read-address channel bundle with master/slave views
interface axi_rd_burst_gen_if #(
  parameter int unsigned AW  = 32,
  parameter int unsigned IDW = 4
);
  logic           o_arvalid;
  logic           i_arready;
  logic [AW-1:0]  o_araddr;
  logic [7:0]     o_arlen;
  logic [2:0]     o_arsize;
  logic [1:0]     o_arburst;
  logic [IDW-1:0] o_arid;

  modport master (
    output o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid,
    input  i_arready
  );

  modport slave (
    input  o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid,
    output i_arready
  );
endinterface

// File: rtl/axi_rd_ost_tracker.sv
// rtl/axi_rd_ost_tracker.sv - outstanding-burst counter and first/last R-burst flag generation
module axi_rd_ost_tracker #(
  parameter int unsigned MAX_OST = 8,
  parameter int unsigned CNT_W   = 17,
  localparam int unsigned OST_W  = $clog2(MAX_OST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             busy_i,
  input  logic             ar_hs_i,
  input  logic             ar_last_i,
  input  logic             rdata_ok_i,
  output logic [OST_W-1:0] ost_cnt_o,
  output logic [OST_W-1:0] ost_next_o,
  output logic             first_o,
  output logic             last_o
);

  logic [OST_W-1:0] ost_q, ost_d;
  logic [CNT_W-1:0] rdone_q, rdone_d;
  logic             all_done_q, all_done_d;
  logic             ok_eff;

  always_comb begin
    // A burst completion with nothing outstanding is a protocol error and is dropped.
    ok_eff     = rdata_ok_i & (ost_q != '0);
    ost_d      = ost_q;
    rdone_d    = rdone_q;
    all_done_d = all_done_q;
    if (ar_hs_i && !ok_eff) begin
      ost_d = ost_q + OST_W'(1);
    end else if (!ar_hs_i && ok_eff) begin
      ost_d = ost_q - OST_W'(1);
    end
    if (clr_i) begin
      rdone_d    = '0;
      all_done_d = 1'b0;
    end else begin
      if (ok_eff)    rdone_d    = rdone_q + CNT_W'(1);
      if (ar_last_i) all_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ost_q      <= '0;
      rdone_q    <= '0;
      all_done_q <= 1'b0;
    end else begin
      ost_q      <= ost_d;
      rdone_q    <= rdone_d;
      all_done_q <= all_done_d;
    end
  end

  assign ost_cnt_o  = ost_q;
  assign ost_next_o = ost_d;
  assign first_o    = busy_i & (rdone_q == '0);
  assign last_o     = busy_i & all_done_q & (ost_q == OST_W'(1));

endmodule

// File: rtl/axi_rd_burst_gen.sv
// rtl/axi_rd_burst_gen.sv - splits one read command into AXI INCR bursts; IDMA_RD_4K_SPLIT_EN adds 4 KB page splitting
module axi_rd_burst_gen
  import idma_rd_pkg::*;
#(
  parameter int unsigned AXI_AW          = 32,
  parameter int unsigned AXI_IDW         = 4,
  parameter int unsigned AXI_DATA_WID    = 128,
  parameter int unsigned LEN_W           = 20,
  parameter int unsigned MAX_BURST_BEATS = 16,
  parameter int unsigned MAX_OST         = 8,
  parameter int unsigned RD_ID           = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [AXI_AW-1:0]   cmd_src_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                dma_done,
  axi_rd_burst_gen_if.master  ar,
  input  logic                axi_burst_rdata_ok,
  output logic [5:0]          strb_first_beat_num,
  output logic [5:0]          strb_last_beat_num,
  output logic                dma_trans_first_burst,
  output logic                dma_trans_last_burst
);

  localparam int unsigned SUM_W  = LEN_W + 1;
  localparam int unsigned BEAT_W = SUM_W - BEAT_SHIFT;
  localparam int unsigned OST_W  = $clog2(MAX_OST + 1);

  rd_state_e         state_q, state_d;
  logic [AXI_AW-1:0] cur_addr_q, cur_addr_d;
  logic [AXI_AW-1:0] araddr_q, araddr_d;
  logic [BEAT_W-1:0] rem_q, rem_d;
  logic [8:0]        beats_q, beats_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [5:0]        sf_q, sf_d, sl_q, sl_d;
  logic              done_q, done_d;

  logic [SUM_W-1:0]  sum_w;
  logic [BEAT_W-1:0] total_w;
  logic [3:0]        last_nib;
  logic [8:0]        page_w, beats_w;
  logic              ar_hs, ar_last, clr;
  logic [OST_W-1:0]  ost_cnt, ost_next;

  always_comb begin
    sum_w    = {1'b0, cmd_len} + SUM_W'(cmd_src_addr[BEAT_SHIFT-1:0]) + SUM_W'(BEAT_BYTES - 1);
    total_w  = sum_w[SUM_W-1:BEAT_SHIFT];
    last_nib = cmd_src_addr[3:0] + cmd_len[3:0];
`ifdef IDMA_RD_4K_SPLIT_EN
    page_w   = 9'd256 - {1'b0, cur_addr_q[11:BEAT_SHIFT]};
`else
    page_w   = 9'(MAX_BURST_BEATS);
`endif
    beats_w  = burst_beats(32'(rem_q), 9'(MAX_BURST_BEATS), page_w);
  end

  assign ar_hs   = (state_q == ST_ADDR) & ar.i_arready;
  assign ar_last = ar_hs & (rem_q == BEAT_W'(beats_q));

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    araddr_d   = araddr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    arlen_d    = arlen_q;
    sf_d       = sf_q;
    sl_d       = sl_q;
    done_d     = 1'b0;
    clr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d = {cmd_src_addr[AXI_AW-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
          rem_d      = total_w;
          sf_d       = 6'(cmd_src_addr[3:0]);
          sl_d       = 6'(last_nib);
          clr        = 1'b1;
          state_d    = (cmd_len == '0) ? ST_WAIT_R : ST_CALC;
        end
      end
      ST_CALC: begin
        beats_d  = beats_w;
        araddr_d = cur_addr_q;
        arlen_d  = 8'(beats_w - 9'd1);
        if (ost_cnt < OST_W'(MAX_OST)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (ar.i_arready) begin
          cur_addr_d = cur_addr_q + AXI_AW'({beats_q, {BEAT_SHIFT{1'b0}}});
          rem_d      = rem_q - BEAT_W'(beats_q);
          state_d    = ar_last ? ST_WAIT_R : ST_CALC;
        end
      end
      ST_WAIT_R: begin
        // Done is registered off the next count so it lands one cycle after the final rlast.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (ost_next == '0) begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      araddr_q   <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      arlen_q    <= '0;
      sf_q       <= '0;
      sl_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      araddr_q   <= araddr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      arlen_q    <= arlen_d;
      sf_q       <= sf_d;
      sl_q       <= sl_d;
      done_q     <= done_d;
    end
  end

  axi_rd_ost_tracker #(
    .MAX_OST (MAX_OST),
    .CNT_W   (BEAT_W)
  ) u_trk (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .clr_i      (clr),
    .busy_i     (busy),
    .ar_hs_i    (ar_hs),
    .ar_last_i  (ar_last),
    .rdata_ok_i (axi_burst_rdata_ok),
    .ost_cnt_o  (ost_cnt),
    .ost_next_o (ost_next),
    .first_o    (dma_trans_first_burst),
    .last_o     (dma_trans_last_burst)
  );

  assign cmd_ready           = (state_q == ST_IDLE);
  assign busy                = (state_q != ST_IDLE);
  assign dma_done            = done_q;
  assign strb_first_beat_num = sf_q;
  assign strb_last_beat_num  = sl_q;

  assign ar.o_arvalid = (state_q == ST_ADDR);
  assign ar.o_araddr  = araddr_q;
  assign ar.o_arlen   = arlen_q;
  assign ar.o_arsize  = 3'($clog2(AXI_DATA_WID / 8));
  assign ar.o_arburst = AXI_BURST_INCR;
  assign ar.o_arid    = AXI_IDW'(RD_ID);

endmodule
